armleo_elastic_buffer: RTL
==========================

// Module: armleo_elastic_buffer
//
// PURPOSE
//  Parametrised successor of the 2-entry register slice: a DEPTH-entry valid/ready
//  elastic buffer that fully decouples two handshake domains. There is no combinational
//  path from out_ready to in_ready, or from in_* to out_*.
//  Adds fill count, almost-full flag, synchronous flush and a PASSTHROUGH mode.
//  Inserted on long/congested paths (bus channels, pipeline stage boundaries).
//
// PARAMETERS
//  PASSTHROUGH  0   1: wires only (out_*=in_*, in_ready=out_ready, count=0, almost_full=0)
//  DW           8   data width in bits, >=1
//  DEPTH        2   number of storage entries, >=2, need not be a power of two
//  AFULL_LVL    DEPTH-1  almost_full asserts when count >= AFULL_LVL (1..DEPTH)
//  CW           $clog2(DEPTH+1)  count width (localparam, not overridable)
//
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    reset; one clock; reset is synchronous and active-high
//  flush        in   1    synchronous clear of all stored entries
//  in_valid     in   1    producer data valid
//  in_data      in   DW   producer data
//  in_ready     out  1    buffer can accept; = !full && !flush, from registered state only
//  out_valid    out  1    head entry valid; = (count != 0)
//  out_data     out  DW   head entry; forced to 0 when out_valid=0
//  out_ready    in   1    consumer accepts head
//  count        out  CW   number of stored entries, 0..DEPTH
//  almost_full  out  1    count >= AFULL_LVL
//
// BEHAVIOUR
//  - Storage: DEPTH x DW array, wr_ptr/rd_ptr in 0..DEPTH-1, count register.
//    Pointers wrap from DEPTH-1 to 0 (explicit compare, not power-of-2 masking).
//  - push = in_valid && in_ready; pop = out_valid && out_ready.
//    Push writes in_data at wr_ptr, wr_ptr++. Pop advances rd_ptr.
//    count += push - pop; push and pop in the same cycle leave count unchanged.
//  - Latency: data pushed at edge N is visible on out_data after edge N
//    (min 1 cycle in->out). Order is strictly FIFO.
//  - Full (count==DEPTH): in_ready=0 even if out_ready=1 in the same cycle.
//    This full decoupling is deliberate; no simultaneous push/pop at full.
//  - Empty (count==0): out_valid=0 and out_data=0. A push into an empty buffer
//    with out_ready=1 is not forwarded in the same cycle.
//  - out_data/out_valid stay stable while out_valid=1 && out_ready=0,
//    except on flush or rst.
//  - Priority: rst > flush > push/pop.
//    rst or flush: count=0, wr_ptr=rd_ptr=0; the push is dropped (in_ready=0 while
//    flush=1) and any pop is void.
//  - Reset values (cycle after rst): in_ready=1, out_valid=0, out_data=0, count=0,
//    almost_full=(AFULL_LVL==0 ? n/a : 0). Array contents are not reset.
//  - Reset/flush mid-transfer discards all entries; no partial output.
//  - in_valid may drop without a handshake; the buffer never depends on in_data
//    when in_valid=0.
//  - DEPTH=2, flush=0 gives throughput and ordering equivalent to the 2-entry slice:
//    1 item/cycle sustained when out_ready=1.
//  - Assertions (sim only): count<=DEPTH; no push when count==DEPTH;
//    no pop when count==0.
//
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=0,
//    count=0 after release.
//  2 Streaming, DEPTH=4: push 0x01..0x10 back-to-back, out_ready=1 -> 16 outputs in order,
//    1/cycle after 1-cycle latency, count<=1.
//  3 Fill/backpressure, DEPTH=4, AFULL_LVL=3: out_ready=0, push 0xA0..0xA5 ->
//    only 0xA0..0xA3 accepted; almost_full at count=3; in_ready=0 at count=4;
//    release -> A0,A1,A2,A3 out.
//  4 Full with out_ready=1: at count=4 with in_valid=1 -> pop happens, no push that cycle,
//    count=3 next cycle, then push resumes.
//  5 Wrap, DEPTH=3: 10 random stall patterns on both sides, 200 items ->
//    scoreboard order exact, pointers wrap 2->0 correctly.
//  6 Flush with count=3 and in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0;
//    neither the in-flight item nor the head is delivered.
//    PASSTHROUGH=1: out_*==in_*, in_ready==out_ready every cycle.

Source files
------------

// File: rtl/armleo_elastic_buffer_if.sv
// Valid/ready handshake bundle used on both sides of armleo_elastic_buffer.
//
// Signals:
//   valid  producer -> consumer  data is valid this cycle
//   ready  consumer -> producer  consumer accepts this cycle
//   data   producer -> consumer  payload, DW bits
//
// Modports:
//   master  drives valid/data, samples ready (producer side)
//   slave   samples valid/data, drives ready (consumer side)

interface armleo_elastic_buffer_if #(
  parameter int unsigned DW = 8
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/armleo_elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer that fully decouples a producer and a consumer.
// in_ready depends only on registered state plus flush, and out_* depend only on
// registered state, so no combinational path crosses the buffer in either direction.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset; empties the buffer
//   flush        synchronous clear of all stored entries; blocks pushes while high
//   in_if        slave side: in_if.valid / in_if.data in, in_if.ready out
//   out_if       master side: out_if.valid / out_if.data out, out_if.ready in
//   count        number of stored entries, 0..DEPTH
//   almost_full  count >= AFULL_LVL
//
// PASSTHROUGH=1 replaces the storage with wires: out=in, in_ready=out_ready,
// count=0, almost_full=0.

module armleo_elastic_buffer #(
  parameter  int unsigned PASSTHROUGH = 0,
  parameter  int unsigned DW          = 8,
  parameter  int unsigned DEPTH       = 2,
  parameter  int unsigned AFULL_LVL   = DEPTH - 1,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  armleo_elastic_buffer_if.slave        in_if,
  armleo_elastic_buffer_if.master       out_if,
  output logic [CW-1:0]                 count,
  output logic                          almost_full
);

  if (PASSTHROUGH != 0) begin : g_pass

    assign out_if.valid = in_if.valid;
    assign out_if.data  = in_if.data;
    assign in_if.ready  = out_if.ready;
    assign count        = '0;
    assign almost_full  = 1'b0;

    // No state in this mode; clock, reset and flush are intentionally ignored.
    logic unused_pt;
    assign unused_pt = ^{clk, rst, flush};

  end else begin : g_buf

    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfCnt   = CW'(AFULL_LVL);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);

    // Full blocks input even when the consumer pops this cycle; that keeps
    // in_ready free of any out_ready dependency.
    assign in_if.ready  = !full && !flush;
    assign out_if.valid = !empty;
    assign out_if.data  = empty ? '0 : mem_q[rd_ptr_q];

    assign push = in_if.valid && in_if.ready;
    assign pop  = !empty && out_if.ready;

    assign count       = count_q;
    assign almost_full = (count_q >= AfCnt);

    // DEPTH need not be a power of two, so pointers wrap on an explicit compare.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage is not reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
      if (push && !rst) begin
        mem_q[wr_ptr_q] <= in_if.data;
      end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
      if (!rst) begin
        assert (count_q <= FullCnt);
        assert (!(push && full));
        assert (!(pop && empty));
      end
    end
`endif

  end

endmodule
